dtw_mem_chk: RTL

- Synthesizable, parametrised successor to the DTW data memory: single-port SRAM array with active-low chip select and WR select.
- Adds byte-lane write enables, a configurable read pipeline depth and a read-valid strobe.
- Adds a built-in region checker that streams golden words in and compares them against a memory window, so result checking is done in hardware rather than by file reads.
- Sits between the DTW processor memory port and the bench/host; the DTW core drives the host port unchanged.

---
 rtl/dtw_mem_chk.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/dtw_mem_chk.sv
// Purpose : single-port DTW data memory with byte-lane writes and a built-in region checker.
// Latency : host read data and o_rvalid appear RD_LAT edges after the read edge; the checker takes RD_LAT+2 cycles per word.
// Backpressure: while o_chk_busy is high, host accesses are dropped. The checker stalls in CMP until i_gold_valid is seen.
// Ports   : i_clk/i_rst          clock, async active-high reset
//           i_CS/i_WR/i_addr/i_data/i_be   host access (CS active low, WR 1=write), byte enables
//           o_data/o_rvalid      host read result and one-cycle valid strobe
//           i_chk_start/i_chk_base/i_chk_len   checker launch (pulse), window base and length
//           i_gold/i_gold_valid/o_gold_ready   golden word stream (valid/ready)
//           o_chk_busy/o_chk_done/o_chk_pass/o_chk_err_cnt/o_chk_err_addr   checker status and result
module dtw_mem_chk #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_CS,
  input  logic                i_WR,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_data,
  input  logic [DATA_W/8-1:0] i_be,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_rvalid,
  input  logic                i_chk_start,
  input  logic [ADDR_W-1:0]   i_chk_base,
  input  logic [ADDR_W:0]     i_chk_len,
  input  logic [DATA_W-1:0]   i_gold,
  input  logic                i_gold_valid,
  output logic                o_gold_ready,
  output logic                o_chk_busy,
  output logic                o_chk_done,
  output logic                o_chk_pass,
  output logic [ERR_W-1:0]    o_chk_err_cnt,
  output logic [ADDR_W-1:0]   o_chk_err_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WT   = 3'd2;
  localparam logic [2:0] ST_CMP  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  // WT lasts RD_LAT cycles so that RD + WT + CMP = RD_LAT+2 cycles per word.
  localparam logic [1:0]        WT_LAST = 2'(RD_LAT - 1);
  localparam logic [ERR_W-1:0]  ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        wt_q, wt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;

  // Read pipe: pd holds data, pv marks a read in flight, ph marks it as a host read.
  logic [DATA_W-1:0] pd_q [RD_LAT];
  logic [DATA_W-1:0] pd_d [RD_LAT];
  logic              pv_q [RD_LAT];
  logic              pv_d [RD_LAT];
  logic              ph_q [RD_LAT];
  logic              ph_d [RD_LAT];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              busy;
  logic              host_wr;
  logic              host_rd;
  logic              int_rd;
  logic [ADDR_W-1:0] chk_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wmask;

  assign busy     = (state_q != ST_IDLE);
  assign host_wr  = ~i_CS & ~busy & i_WR;
  assign host_rd  = ~i_CS & ~busy & ~i_WR;
  assign int_rd   = (state_q == ST_RD);
  // Truncation to ADDR_W makes the checker window wrap at the top of the array.
  assign chk_addr = base_q + idx_q[ADDR_W-1:0];
  assign rd_addr  = int_rd ? chk_addr : i_addr;

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign wmask[8*b +: 8] = {8{i_be[b]}};
  end

  always_ff @(posedge i_clk) begin
    if (host_wr) begin
      mem[i_addr] <= (mem[i_addr] & ~wmask) | (i_data & wmask);
    end
  end

  // Stages only load when a read moves into them, so the last stage keeps the
  // most recent internal word stable for CMP however long gold data stalls.
  assign pv_d[0] = host_rd | int_rd;
  assign ph_d[0] = host_rd;
  assign pd_d[0] = pv_d[0] ? mem[rd_addr] : pd_q[0];

  for (genvar k = 1; k < RD_LAT; k++) begin : g_pipe
    assign pv_d[k] = pv_q[k-1];
    assign ph_d[k] = ph_q[k-1];
    assign pd_d[k] = pv_q[k-1] ? pd_q[k-1] : pd_q[k];
  end

  // o_data only follows host reads; checker reads never disturb it.
  assign rd_data_d = (pv_d[RD_LAT-1] & ph_d[RD_LAT-1]) ? pd_d[RD_LAT-1] : rd_data_q;

  for (genvar k = 0; k < RD_LAT; k++) begin : g_stage
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        pd_q[k] <= '0;
        pv_q[k] <= 1'b0;
        ph_q[k] <= 1'b0;
      end else begin
        pd_q[k] <= pd_d[k];
        pv_q[k] <= pv_d[k];
        ph_q[k] <= ph_d[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    wt_d       = wt_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_chk_start) begin
          base_d     = i_chk_base;
          len_d      = i_chk_len;
          idx_d      = '0;
          err_cnt_d  = '0;
          err_addr_d = '0;
          pass_d     = 1'b0;
          state_d    = (i_chk_len == '0) ? ST_FIN : ST_RD;
        end
      end
      ST_RD: begin
        wt_d    = '0;
        state_d = ST_WT;
      end
      ST_WT: begin
        if (wt_q == WT_LAST) begin
          state_d = ST_CMP;
        end else begin
          wt_d = wt_q + 2'd1;
        end
      end
      ST_CMP: begin
        if (i_gold_valid) begin
          if (i_gold != pd_q[RD_LAT-1]) begin
            // The counter saturates and never wraps, so zero means "no mismatch yet".
            if (err_cnt_q == '0) begin
              err_addr_d = chk_addr;
            end
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_ONE;
            end
          end
          idx_d   = idx_q + IDX_ONE;
          state_d = (idx_d == len_q) ? ST_FIN : ST_RD;
        end
      end
      ST_FIN: begin
        pass_d  = (err_cnt_q == '0);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      wt_q       <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      wt_q       <= wt_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_data         = rd_data_q;
  assign o_rvalid       = pv_q[RD_LAT-1] & ph_q[RD_LAT-1];
  assign o_gold_ready   = (state_q == ST_CMP);
  assign o_chk_busy     = busy;
  assign o_chk_done     = done_q;
  assign o_chk_pass     = pass_q;
  assign o_chk_err_cnt  = err_cnt_q;
  assign o_chk_err_addr = err_addr_q;

endmodule
